crc32_fcs_unit: RTL and testbench
=================================

CRC32_FCS_UNIT -- requirements
Module: crc32_fcs_unit

Interface
REQ-001 Parameter DATA_W, default 8: input word width in bits; legal values 8, 16, 32, 64; NB = DATA_W/8 bytes per word.
REQ-002 Parameter CHECK_RESIDUE, default 32'hDEBB20E3: expected raw register value after a frame plus its FCS.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts the word; transfer happens when in_valid && in_ready.
REQ-007 in_sop  input  1  word is the first of a frame.
REQ-008 in_eop  input  1  word is the last of a frame.
REQ-009 in_data  input  DATA_W  frame bytes; byte k is in bits [8k+7:8k]; byte 0 is first on the wire.
REQ-010 in_keep  input  NB  valid-byte mask, contiguous from bit 0; honoured only on eop words (all bytes valid otherwise).
REQ-011 in_mode  input  1  0 = generate (append FCS), 1 = check (verify trailing FCS); sampled on the sop transfer only.
REQ-012 fcs_valid / fcs_ready / fcs_byte[7:0] / fcs_last  out/in/out/out  FCS byte stream in generate mode.
REQ-013 crc_value  output  32  final CRC (~register) of the last completed frame.
REQ-014 res_valid / crc_ok / crc_err  output  1 each  one-cycle result pulses.

Function
REQ-015 CRC-32 (IEEE 802.3), reflected polynomial 0xEDB88320; bits processed LSB first within each byte; all NB bytes of a word processed in one cycle.
REQ-016 Register loads 32'hFFFFFFFF on every sop transfer before that word's bytes are folded in.
REQ-017 States: IDLE, CALC, FCS.
REQ-018 IDLE: in_ready=1; a transfer without in_sop is ignored.
REQ-019 IDLE to CALC: on a sop transfer without eop.
REQ-020 CALC: in_ready=1; each transfer updates the register.
REQ-021 A sop transfer in CALC aborts the current frame (no result) and restarts.
REQ-022 On an eop transfer, only the bytes with in_keep set are folded in; in_keep=0 contributes no bytes.
REQ-023 A word carrying both sop and eop is a complete single-word frame.
REQ-024 Cycle after an eop transfer: crc_value = ~register, held until the next eop.
REQ-025 Cycle after an eop transfer, check mode: res_valid=1 for one cycle; crc_ok=1 iff register == CHECK_RESIDUE; otherwise crc_err=1; state returns to IDLE.
REQ-026 Cycle after an eop transfer, generate mode: res_valid=1, crc_ok=0, crc_err=0; state goes to FCS.
REQ-027 FCS state: in_ready=0; fcs_valid=1; fcs_byte = crc_value[7:0], [15:8], [23:16], [31:24] in order.
REQ-028 FCS state: fcs_byte advances only on fcs_valid && fcs_ready; fcs_byte and fcs_last stay stable while fcs_ready=0.
REQ-029 FCS state: fcs_last=1 with byte 3; accepting byte 3 returns the block to IDLE.
REQ-030 Back-to-back frames: a sop is accepted in the cycle after an eop in check mode, and in the cycle after fcs_last is accepted in generate mode.
REQ-031 Mode is latched per frame; in_mode changes mid-frame have no effect.

Reset
REQ-032 rst on any cycle, including mid-frame or mid-FCS: state=IDLE; register=32'hFFFFFFFF; crc_value=0; res_valid=0; crc_ok=0; crc_err=0; fcs_valid=0; fcs_byte=0; fcs_last=0.
REQ-033 In-flight frame after rst: discarded; no result is produced.
REQ-034 in_ready after rst: 1 in the first cycle after rst deasserts.

Verification
REQ-035 DATA_W=8, generate, bytes 31..39 ("123456789"), fcs_ready=1 -> crc_value=32'hCBF43926; fcs_byte 26,39,F4,CB on 4 consecutive cycles; fcs_last on CB.
REQ-036 DATA_W=32, words 32'h34333231, 32'h38373635, 32'h00000039 with in_keep=4'b0001 on eop -> crc_value=32'hCBF43926; res_valid exactly 1 cycle after eop.
REQ-037 DATA_W=8, check, "123456789" then 26 39 F4 CB -> crc_ok=1; same stimulus with last byte 4A -> crc_err=1; frames driven back-to-back with no idle cycle.
REQ-038 Generate mode with fcs_ready=0 for 3 cycles at byte 1 -> fcs_byte stays 39 and in_ready stays 0 throughout; then completes normally.
REQ-039 sop re-asserted mid-frame before "123456789" -> result equals the clean 32'hCBF43926; exactly one res_valid pulse.
REQ-040 rst during FCS byte 2 -> all outputs 0 next cycle; in_ready=1; a following frame computes correctly.

Source files
------------

// File: rtl/crc32_fcs_unit.sv
// crc32_fcs_unit: CRC-32 (IEEE 802.3) stream unit; in_* frame words in, fcs_* FCS bytes out (generate), crc_value/res_valid/crc_ok/crc_err results
module crc32_fcs_unit #(
  parameter int          DATA_W        = 8,
  parameter logic [31:0] CHECK_RESIDUE = 32'hDEBB20E3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W/8-1:0]   in_keep,
  input  logic                  in_mode,
  output logic                  fcs_valid,
  input  logic                  fcs_ready,
  output logic [7:0]            fcs_byte,
  output logic                  fcs_last,
  output logic [31:0]           crc_value,
  output logic                  res_valid,
  output logic                  crc_ok,
  output logic                  crc_err
);
  localparam int NB = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, CALC, FCS} state_t;
  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d, crcv_q, crcv_d, folded;
  logic [1:0]  idx_q, idx_d;
  logic        mode_q, mode_d, res_q, res_d, ok_q, ok_d, err_q, err_d;
  logic        accept, eff_mode;

  function automatic logic [31:0] fold(input logic [31:0] c, input logic [DATA_W-1:0] d, input logic [NB-1:0] en);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < NB; k++)
      for (int b = 0; b < 8; b++)
        if (en[k]) r = (r >> 1) ^ (32'hEDB88320 & {32{r[0] ^ d[8*k+b]}});
    return r;
  endfunction

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= 32'hFFFFFFFF;
      crcv_q  <= 32'd0;
      idx_q   <= 2'd0;
      mode_q  <= 1'b0;
      res_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      crcv_q  <= crcv_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end

  always_comb begin
    accept   = in_valid && state_q != FCS && (in_sop || state_q == CALC);
    eff_mode = in_sop ? in_mode : mode_q;
    folded   = fold(in_sop ? 32'hFFFFFFFF : crc_q, in_data, in_eop ? in_keep : {NB{1'b1}});
    crc_d    = accept ? folded : crc_q;
    mode_d   = accept && in_sop ? in_mode : mode_q;
    res_d    = accept && in_eop;
    ok_d     = res_d && eff_mode && folded == CHECK_RESIDUE;
    err_d    = res_d && eff_mode && folded != CHECK_RESIDUE;
    crcv_d   = res_d ? ~folded : crcv_q;
    idx_d    = state_q == FCS && fcs_ready ? idx_q + 2'd1 : idx_q;
    state_d  = state_q;
    if (state_q == FCS) begin
      if (fcs_ready && idx_q == 2'd3) state_d = IDLE;
    end else if (accept) begin
      if (!in_eop) state_d = CALC;
      else if (eff_mode) state_d = IDLE;
      else state_d = FCS;
    end
  end

  always_comb begin
    in_ready  = state_q != FCS;
    fcs_valid = state_q == FCS;
    fcs_byte  = fcs_valid ? crcv_q[{idx_q, 3'b000} +: 8] : 8'd0;
    fcs_last  = fcs_valid && idx_q == 2'd3;
    crc_value = crcv_q;
    res_valid = res_q;
    crc_ok    = ok_q;
    crc_err   = err_q;
  end
endmodule

// File: tb/tb_crc32_fcs_unit.sv
// tb_crc32_fcs_unit: byte-queue reference model with per-cycle compare plus directed literal checks
module tb_crc32_fcs_unit;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  typedef logic [7:0] bq_t[$];

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic v8 = 0, s8 = 0, e8 = 0, k8 = 1, m8 = 0, fr8 = 1;
  logic [7:0] d8 = 0;
  logic rdy8, fv8, fl8, rv8, ok8, er8;
  logic [7:0] fb8;
  logic [31:0] cv8;

  logic v32 = 0, s32 = 0, e32 = 0, m32 = 0, fr32 = 1;
  logic [3:0] k32 = 4'hF;
  logic [31:0] d32 = 0;
  logic rdy32, fv32, fl32, rv32, ok32, er32;
  logic [7:0] fb32;
  logic [31:0] cv32;

  int total = 0, bad = 0, resc = 0;
  logic chk_en = 0;

  crc32_fcs_unit #(.DATA_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_sop(s8), .in_eop(e8),
    .in_data(d8), .in_keep(k8), .in_mode(m8), .fcs_valid(fv8), .fcs_ready(fr8),
    .fcs_byte(fb8), .fcs_last(fl8), .crc_value(cv8), .res_valid(rv8), .crc_ok(ok8), .crc_err(er8));

  crc32_fcs_unit #(.DATA_W(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_sop(s32), .in_eop(e32),
    .in_data(d32), .in_keep(k32), .in_mode(m32), .fcs_valid(fv32), .fcs_ready(fr32),
    .fcs_byte(fb32), .fcs_last(fl32), .crc_value(cv32), .res_valid(rv32), .crc_ok(ok32), .crc_err(er32));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] tbl [256];
  function automatic logic [31:0] crc_raw(input bq_t q);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) c = (c >> 8) ^ tbl[c[7:0] ^ q[i]];
    return c;
  endfunction

  bq_t fq, mq;
  logic m_active = 0, m_mode = 0, m_res = 0, m_ok = 0, m_err = 0;
  logic [31:0] m_cv = 0;

  always @(posedge clk) begin : model
    logic [31:0] raw;
    logic rdy;
    if (rst) begin
      fq.delete(); mq.delete();
      m_active = 0; m_res = 0; m_ok = 0; m_err = 0; m_cv = 0;
    end else begin
      rdy = mq.size() == 0;
      m_res = 0; m_ok = 0; m_err = 0;
      if (!rdy && fr8) void'(mq.pop_front());
      if (v8 && rdy && (s8 || m_active)) begin
        if (s8) begin fq.delete(); m_mode = m8; end
        if (!e8 || k8) fq.push_back(d8);
        if (e8) begin
          raw = crc_raw(fq);
          m_cv = ~raw; m_res = 1; m_active = 0;
          if (m_mode) begin m_ok = raw == RESIDUE; m_err = raw != RESIDUE; end
          else for (int i = 0; i < 4; i++) mq.push_back(m_cv[8*i +: 8]);
        end else m_active = 1;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    if (rv8) resc++;
    chk("m_in_ready", rdy8, mq.size() == 0);
    chk("m_fcs_valid", fv8, mq.size() != 0);
    chk("m_fcs_byte", fb8, mq.size() != 0 ? mq[0] : 8'd0);
    chk("m_fcs_last", fl8, mq.size() == 1);
    chk("m_crc_value", cv8, m_cv);
    chk("m_res_valid", rv8, m_res);
    chk("m_crc_ok", ok8, m_ok);
    chk("m_crc_err", er8, m_err);
  end

  task automatic send8(input logic [7:0] d, input logic s, input logic e, input logic md, input logic kp);
    int n = 0;
    v8 = 1; d8 = d; s8 = s; e8 = e; m8 = md; k8 = kp;
    while (!rdy8 && n < 50) begin @(posedge clk); #1; n++; end
    if (!rdy8) begin total++; bad++; $display("FAIL send8_timeout: in_ready=%b required 1", rdy8); end
    @(posedge clk); #1;
    v8 = 0; s8 = 0; e8 = 0;
  endtask

  task automatic frame8(input bq_t q, input logic md);
    foreach (q[i]) send8(q[i], i == 0, i == q.size() - 1, i == 0 ? md : ~md, 1'b1);
  endtask

  task automatic drain8();
    int n = 0;
    while (fv8 && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain8", fv8, 0);
  endtask

  task automatic send32(input logic [31:0] d, input logic s, input logic e, input logic md, input logic [3:0] kp);
    int n = 0;
    v32 = 1; d32 = d; s32 = s; e32 = e; m32 = md; k32 = kp;
    while (!rdy32 && n < 50) begin @(posedge clk); #1; n++; end
    if (!rdy32) begin total++; bad++; $display("FAIL send32_timeout: in_ready=%b required 1", rdy32); end
    @(posedge clk); #1;
    v32 = 0; s32 = 0; e32 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t msg, good, badf;
    logic [7:0] fexp [4];
    int r0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = i;
      repeat (8) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
      tbl[i] = c;
    end
    fexp = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    good = msg; good.push_back(8'h26); good.push_back(8'h39); good.push_back(8'hF4); good.push_back(8'hCB);
    badf = good; badf[12] = 8'h4A;
    chk("pin_model_crc", ~crc_raw(msg), 32'hCBF43926);
    chk("pin_model_residue", crc_raw(good), RESIDUE);
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    chk("rst_in_ready", rdy8, 1);
    chk("rst_crc_value", cv8, 0);
    chk("rst_fcs_valid", fv8, 0);
    // generate, fcs_ready held high
    frame8(msg, 1'b0);
    chk("gen_crc", cv8, 32'hCBF43926);
    chk("gen_res", rv8, 1);
    chk("gen_ok", ok8, 0);
    for (int i = 0; i < 4; i++) begin
      chk("gen_byte", fb8, fexp[i]);
      chk("gen_last", fl8, i == 3);
      @(posedge clk); #1;
    end
    chk("gen_back_ready", rdy8, 1);
    // check mode, good then corrupted, back to back
    frame8(good, 1'b1);
    chk("chk_ok", ok8, 1);
    chk("chk_ok_err", er8, 0);
    frame8(badf, 1'b1);
    chk("chk_err", er8, 1);
    chk("chk_err_ok", ok8, 0);
    // eop word with keep=0 contributes no byte
    foreach (msg[i]) send8(msg[i], i == 0, 1'b0, 1'b0, 1'b1);
    send8(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("keep0_crc", cv8, 32'hCBF43926);
    drain8();
    // fcs_ready stall at byte 1
    frame8(msg, 1'b0);
    @(posedge clk); #1;
    chk("stall_pre", fb8, 8'h39);
    fr8 = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_byte", fb8, 8'h39);
      chk("stall_ready", rdy8, 0);
    end
    fr8 = 1;
    @(posedge clk); #1;
    chk("stall_resume", fb8, 8'hF4);
    drain8();
    // sop re-asserted mid-frame
    r0 = resc;
    send8(8'h41, 1'b1, 1'b0, 1'b0, 1'b1);
    send8(8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    frame8(msg, 1'b0);
    chk("abort_crc", cv8, 32'hCBF43926);
    drain8();
    chk("abort_pulses", resc - r0, 1);
    // reset mid-frame discards the frame
    send8(8'h31, 1'b1, 1'b0, 1'b0, 1'b1);
    send8(8'h32, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1; @(posedge clk); #1; rst = 0;
    r0 = resc;
    send8(8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("rst_frame_noresult", resc - r0, 0);
    // reset during FCS byte 2
    frame8(msg, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstfcs_byte2", fb8, 8'hF4);
    rst = 1; @(posedge clk); #1; rst = 0;
    chk("rstfcs_fv", fv8, 0);
    chk("rstfcs_fb", fb8, 0);
    chk("rstfcs_fl", fl8, 0);
    chk("rstfcs_cv", cv8, 0);
    chk("rstfcs_rv", rv8, 0);
    chk("rstfcs_ok_err", {ok8, er8}, 0);
    chk("rstfcs_ready", rdy8, 1);
    frame8(msg, 1'b0);
    chk("rstfcs_next_crc", cv8, 32'hCBF43926);
    drain8();
    // 32-bit datapath, partial keep on eop
    send32(32'h34333231, 1'b1, 1'b0, 1'b0, 4'hF);
    send32(32'h38373635, 1'b0, 1'b0, 1'b0, 4'hF);
    chk("w32_no_early_res", rv32, 0);
    send32(32'h00000039, 1'b0, 1'b1, 1'b0, 4'b0001);
    chk("w32_res", rv32, 1);
    chk("w32_crc", cv32, 32'hCBF43926);
    chk("w32_fcs0", fb32, 8'h26);
    @(posedge clk); #1;
    chk("w32_res_pulse", rv32, 0);
    send32(32'h34333231, 1'b1, 1'b0, 1'b1, 4'hF);
    send32(32'h38373635, 1'b0, 1'b0, 1'b0, 4'hF);
    send32(32'hF4392639, 1'b0, 1'b0, 1'b0, 4'hF);
    send32(32'h000000CB, 1'b0, 1'b1, 1'b0, 4'b0001);
    chk("w32_chk_ok", ok32, 1);
    chk("w32_chk_err", er32, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
